// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the UART program loader and its UART neighbours.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         DEFAULT_CLK_FREQ  = 10_000_000;

  function automatic logic in_frame(input loader_state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Valid/ready memory write port driven by the loader.
interface uart_loader_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (output mem_valid, output mem_addr, output mem_wdata, input mem_ready);
  modport slave  (input mem_valid, input mem_addr, input mem_wdata, output mem_ready);

endinterface

// File: rtl/uart_idle_timer.sv
// Inter-byte gap counter; expired stays high once the count reaches TIMEOUT_CYCLES.
module uart_idle_timer #(
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/uart_loader.sv
// Parses SYNC/LEN/DATA/CSUM frames from uart_rx and writes the image to memory,
// holding the CPU in reset until a frame with a good checksum has been loaded.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [7:0]            SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int                    TIMEOUT_CYCLES = DEFAULT_CLK_FREQ,
  parameter int                    HOLD_AT_RESET  = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  uart_loader_if.master mem,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         err_checksum,
  output logic         err_overrun,
  output logic         err_timeout,
  output logic [15:0]  word_count
);

  loader_state_t state, next_state;

  logic                  rx_prev, byte_stb;
  logic [7:0]            byte_q, pend_data, cur_byte, checksum;
  logic                  pend_valid, byte_avail, handshake, overrun;
  logic                  frame_active, timer_expired;
  logic [15:0]           len_q;
  logic [1:0]            byte_idx;
  logic                  mem_valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  do_start, do_len_lo, do_len_hi, do_data;
  logic                  do_csum_ok, do_csum_bad, do_overrun, do_timeout;

  assign mem.mem_valid = mem_valid_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign frame_active = in_frame(state);
  assign busy         = frame_active;
  assign handshake    = mem_valid_q && mem.mem_ready;
  // A stored byte is always older than a fresh strobe, so it is consumed first.
  assign byte_avail   = !mem_valid_q && (pend_valid || byte_stb);
  assign cur_byte     = pend_valid ? pend_data : byte_q;
  assign overrun      = (state == ST_DATA) && byte_stb && mem_valid_q && pend_valid;

  uart_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (byte_stb || !frame_active),
    .enable  (frame_active && !mem_valid_q),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state  = state;
    do_start    = 1'b0;
    do_len_lo   = 1'b0;
    do_len_hi   = 1'b0;
    do_data     = 1'b0;
    do_csum_ok  = 1'b0;
    do_csum_bad = 1'b0;
    do_overrun  = 1'b0;
    do_timeout  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (byte_avail && cur_byte == SYNC_BYTE) begin
          do_start   = 1'b1;
          next_state = ST_LEN0;
        end
      end
      ST_LEN0: begin
        if (byte_avail) begin
          do_len_lo  = 1'b1;
          next_state = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (byte_avail) begin
          do_len_hi  = 1'b1;
          next_state = ({cur_byte, len_q[7:0]} == 16'd0) ? ST_CSUM : ST_DATA;
        end
      end
      ST_DATA: begin
        do_data = byte_avail;
        if (handshake && (word_count + 16'd1) == len_q) next_state = ST_CSUM;
      end
      ST_CSUM: begin
        if (byte_avail) begin
          if (cur_byte == checksum) begin
            do_csum_ok = 1'b1;
            next_state = ST_DONE;
          end else begin
            do_csum_bad = 1'b1;
            next_state  = ST_ERROR;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
    // Errors pre-empt whatever the frame parser wanted to do this cycle.
    if (frame_active && (overrun || timer_expired)) begin
      next_state  = ST_ERROR;
      do_len_lo   = 1'b0;
      do_len_hi   = 1'b0;
      do_data     = 1'b0;
      do_csum_ok  = 1'b0;
      do_csum_bad = 1'b0;
      do_overrun  = overrun;
      do_timeout  = !overrun;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_prev      <= 1'b0;
      byte_stb     <= 1'b0;
      byte_q       <= '0;
      pend_valid   <= 1'b0;
      pend_data    <= '0;
      len_q        <= '0;
      checksum     <= '0;
      byte_idx     <= '0;
      mem_valid_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      word_count   <= '0;
      cpu_hold     <= (HOLD_AT_RESET != 0);
      done         <= 1'b0;
      err_checksum <= 1'b0;
      err_overrun  <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      rx_prev  <= rx_valid;
      byte_stb <= rx_valid && !rx_prev;
      byte_q   <= rx_data;

      if (next_state == ST_ERROR && state != ST_ERROR) begin
        pend_valid <= 1'b0;
      end else if (byte_stb && (mem_valid_q || pend_valid)) begin
        pend_valid <= 1'b1;
        pend_data  <= byte_q;
      end else if (byte_avail) begin
        pend_valid <= 1'b0;
      end

      if (handshake) begin
        mem_valid_q <= 1'b0;
        word_count  <= word_count + 16'd1;
      end

      if (do_start) begin
        word_count   <= '0;
        checksum     <= '0;
        byte_idx     <= '0;
        cpu_hold     <= 1'b1;
        done         <= 1'b0;
        err_checksum <= 1'b0;
        err_overrun  <= 1'b0;
        err_timeout  <= 1'b0;
      end
      if (do_len_lo) len_q[7:0]  <= cur_byte;
      if (do_len_hi) len_q[15:8] <= cur_byte;

      // Bytes shift in from the top so the first byte lands in [7:0] after four.
      if (do_data) begin
        wdata_q  <= {cur_byte, wdata_q[31:8]};
        checksum <= checksum ^ cur_byte;
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          mem_valid_q <= 1'b1;
          addr_q      <= BASE_ADDR + ADDR_WIDTH'({word_count, 2'b00});
        end
      end

      if (do_csum_ok) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (do_csum_bad) err_checksum <= 1'b1;
      if (do_overrun)  err_overrun  <= 1'b1;
      if (do_timeout)  err_timeout  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: a frame-level model predicts the memory writes and
// final status, and a monitor checks every handshake and every stalled cycle.
module tb_uart_loader;
  import uart_loader_pkg::*;

  typedef logic [7:0] byte_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cpu_hold, busy, done, err_checksum, err_overrun, err_timeout;
  logic [15:0] word_count;

  int  errors = 0;
  int  checks = 0;
  wr_t exp_q[$];
  wr_t seen_q[$];

  uart_loader_if #(.ADDR_WIDTH(32)) mem_bus ();

  uart_loader #(
    .ADDR_WIDTH     (32),
    .BASE_ADDR      (32'h0000_0000),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TIMEOUT),
    .HOLD_AT_RESET  (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .mem          (mem_bus),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err_checksum (err_checksum),
    .err_overrun  (err_overrun),
    .err_timeout  (err_timeout),
    .word_count   (word_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Whole-frame model: LEN little-endian, words little-endian, checksum = XOR of data bytes.
  task automatic model_frame(input byte_t f[$], output logic exp_done, output logic [15:0] exp_words);
    int    len;
    byte_t x;
    wr_t   e;
    x   = 8'h00;
    len = int'({f[2], f[1]});
    for (int w = 0; w < len; w++) begin
      e.addr = 32'(4 * w);
      e.data = {f[3+4*w+3], f[3+4*w+2], f[3+4*w+1], f[3+4*w]};
      for (int k = 0; k < 4; k++) x = x ^ f[3+4*w+k];
      exp_q.push_back(e);
    end
    exp_done  = (f[3+4*len] == x);
    exp_words = 16'(len);
  endtask

  task automatic apply_stimulus(input byte_t b, input int hold);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bytes(input byte_t f[$], input int hold);
    foreach (f[i]) apply_stimulus(f[i], hold);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic exp_done, input logic [15:0] exp_words);
    check_output({tag, "_done"}, done, exp_done);
    check_output({tag, "_err_checksum"}, err_checksum, !exp_done);
    check_output({tag, "_cpu_hold"}, cpu_hold, !exp_done);
    check_output({tag, "_word_count"}, word_count, exp_words);
    check_output({tag, "_busy"}, busy, 1'b0);
    check_output({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  initial begin : monitor
    logic        stall_prev;
    logic [31:0] addr_prev, data_prev;
    wr_t         w;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_output("valid_held", mem_bus.mem_valid, 1'b1);
          check_output("addr_stable", mem_bus.mem_addr, addr_prev);
          check_output("data_stable", mem_bus.mem_wdata, data_prev);
        end
        if (mem_bus.mem_valid && mem_bus.mem_ready) begin
          w.addr = mem_bus.mem_addr;
          w.data = mem_bus.mem_wdata;
          seen_q.push_back(w);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write: got 0x%0h@0x%0h, expected no write", w.data, w.addr);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            check_output("write_addr", w.addr, e.addr);
            check_output("write_data", w.data, e.data);
          end
        end
        stall_prev = mem_bus.mem_valid && !mem_bus.mem_ready;
        addr_prev  = mem_bus.mem_addr;
        data_prev  = mem_bus.mem_wdata;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    byte_t       f[$];
    logic        exp_done;
    logic [15:0] exp_words;

    reset_n           = 1'b0;
    rx_valid          = 1'b0;
    rx_data           = 8'h00;
    mem_bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_cpu_hold", cpu_hold, 1'b1);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_done", done, 1'b0);
    check_output("rst_errs", {err_checksum, err_overrun, err_timeout}, 3'b000);
    check_output("rst_word_count", word_count, 16'd0);
    check_output("rst_mem_valid", mem_bus.mem_valid, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] two-word frame, good checksum");
    // Good checksum is the XOR of the eight data bytes: 0x88.
    f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    seen_q.delete();
    model_frame(f, exp_done, exp_words);
    send_bytes(f, 1);
    check_frame("t1", exp_done, exp_words);
    check_output("t1_lit_done", done, 1'b1);
    check_output("t1_lit_count", seen_q.size(), 2);
    check_output("t1_lit_w0", seen_q[0].data, 32'h4433_2211);
    check_output("t1_lit_a1", seen_q[1].addr, 32'h0000_0004);
    check_output("t1_lit_w1", seen_q[1].data, 32'h8877_6655);

    $display("[TB] same frame, bad checksum");
    f[11] = 8'h00;
    seen_q.delete();
    model_frame(f, exp_done, exp_words);
    send_bytes(f, 1);
    check_frame("t2", exp_done, exp_words);
    check_output("t2_lit_err", err_checksum, 1'b1);
    check_output("t2_lit_count", seen_q.size(), 2);

    $display("[TB] empty frame, junk byte, restart");
    f = '{8'hA5, 8'h00, 8'h00, 8'h00};
    seen_q.delete();
    model_frame(f, exp_done, exp_words);
    send_bytes(f, 1);
    check_frame("t3", exp_done, exp_words);
    check_output("t3_lit_count", seen_q.size(), 0);
    apply_stimulus(8'h7E, 1);
    check_output("t3_junk_done", done, 1'b1);
    check_output("t3_junk_busy", busy, 1'b0);
    apply_stimulus(8'hA5, 1);
    check_output("t3_restart_done", done, 1'b0);
    check_output("t3_restart_busy", busy, 1'b1);
    check_output("t3_restart_hold", cpu_hold, 1'b1);
    f = '{8'h00, 8'h00, 8'h00};
    send_bytes(f, 1);
    check_output("t3_second_done", done, 1'b1);

    $display("[TB] memory stall with overrun");
    mem_bus.mem_ready = 1'b0;
    f = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_bytes(f, 1);
    exp_q.push_back('{addr: 32'h0, data: 32'h4433_2211});
    check_output("t4_valid", mem_bus.mem_valid, 1'b1);
    check_output("t4_addr", mem_bus.mem_addr, 32'h0);
    check_output("t4_data", mem_bus.mem_wdata, 32'h4433_2211);
    apply_stimulus(8'h55, 1);
    check_output("t4_first_stalled_ovr", err_overrun, 1'b0);
    check_output("t4_first_stalled_busy", busy, 1'b1);
    apply_stimulus(8'h66, 1);
    check_output("t4_second_stalled_ovr", err_overrun, 1'b1);
    check_output("t4_second_stalled_valid", mem_bus.mem_valid, 1'b1);
    check_output("t4_second_stalled_busy", busy, 1'b0);
    check_output("t4_second_stalled_hold", cpu_hold, 1'b1);
    mem_bus.mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    check_output("t4_after_valid", mem_bus.mem_valid, 1'b0);
    check_output("t4_after_count", word_count, 16'd1);
    check_output("t4_writes_left", exp_q.size(), 0);

    $display("[TB] inter-byte timeout");
    f = '{8'hA5, 8'h01, 8'h00, 8'h11};
    send_bytes(f, 1);
    repeat (TIMEOUT / 2) @(negedge clk);
    check_output("t5_early_timeout", err_timeout, 1'b0);
    check_output("t5_early_busy", busy, 1'b1);
    repeat (TIMEOUT / 2 + 100) @(negedge clk);
    check_output("t5_timeout", err_timeout, 1'b1);
    check_output("t5_busy", busy, 1'b0);
    check_output("t5_hold", cpu_hold, 1'b1);
    check_output("t5_done", done, 1'b0);

    $display("[TB] long rx_valid, reset mid-frame");
    f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    send_bytes(f, 5);
    check_output("t6_mid_busy", busy, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_output("t6_rst_hold", cpu_hold, 1'b1);
    check_output("t6_rst_busy", busy, 1'b0);
    check_output("t6_rst_errs", {done, err_checksum, err_overrun, err_timeout}, 4'b0000);
    check_output("t6_rst_count", word_count, 16'd0);
    check_output("t6_rst_valid", mem_bus.mem_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    f = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    seen_q.delete();
    model_frame(f, exp_done, exp_words);
    send_bytes(f, 5);
    check_frame("t6", exp_done, exp_words);
    check_output("t6_lit_done", done, 1'b1);
    check_output("t6_lit_w0", seen_q[0].data, 32'hEFBE_ADDE);

    repeat (3) @(negedge clk);
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
